// File: rtl/cpu6502_interrupt_controller_if.sv
// Handshake between the 6502 microcode sequencer (master) and the interrupt controller (slave).
// Carries the I flag, the ack/vector-fetch strobes and the prioritised request with its vector.
interface cpu6502_interrupt_controller_if;
  logic       iFlag;
  logic       intAck;
  logic       vectorFetch;
  logic       intRequest;
  logic [1:0] intType;
  logic [7:0] vectorLow;
  logic       busy;

  modport master (
    output iFlag, intAck, vectorFetch,
    input  intRequest, intType, vectorLow, busy
  );

  modport slave (
    input  iFlag, intAck, vectorFetch,
    output intRequest, intType, vectorLow, busy
  );
endinterface

// File: rtl/cpu6502_interrupt_controller.sv
// Prioritised RESET/NMI/IRQ sequencer for the 6502 core, with NMI hijack of an in-progress IRQ.
// Define CPU6502_IRQ_EDGE_MODE_EN to add per-channel edge-triggered IRQs with software clear.
module cpu6502_interrupt_controller #(
  parameter int IRQ_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    enable,
  input  logic                    nNMI,
  input  logic [IRQ_CHANNELS-1:0] irqIn,
  input  logic                    maskWrite,
  input  logic [IRQ_CHANNELS-1:0] maskData,
`ifdef CPU6502_IRQ_EDGE_MODE_EN
  input  logic [IRQ_CHANNELS-1:0] irqEdgeMode,
  input  logic [IRQ_CHANNELS-1:0] irqClear,
`endif
  output logic [2:0]              irqChannel,
  output logic [IRQ_CHANNELS-1:0] irqMask,
  cpu6502_interrupt_controller_if.slave core
);

  typedef enum logic [1:0] {
    RESET_PEND = 2'd0,
    IDLE       = 2'd1,
    SERVICE    = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_NONE  = 2'd0;
  localparam logic [1:0] TYPE_IRQ   = 2'd1;
  localparam logic [1:0] TYPE_NMI   = 2'd2;
  localparam logic [1:0] TYPE_RESET = 2'd3;

  state_t stateReg, stateNext;

  logic [SYNC_STAGES-1:0]                   nmiSyncReg;
  logic [SYNC_STAGES-1:0][IRQ_CHANNELS-1:0] irqSyncReg;
  logic                                     nmiPrevReg;
  logic                                     nmiLatchReg;
  logic [IRQ_CHANNELS-1:0]                  irqMaskReg;

  logic                    sNmi;
  logic [IRQ_CHANNELS-1:0] sIrq;
  logic [IRQ_CHANNELS-1:0] irqSource;
  logic [IRQ_CHANNELS-1:0] irqMasked;
  logic                    irqActive;
  logic                    nmiEdge;
  logic                    nmiCommit;

  logic       intRequestNext;
  logic [1:0] intTypeNext;
  logic [7:0] vectorLowNext;
  logic       busyNext;

  // Synchronisers; stage 0 samples the pins, the last stage feeds the logic.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      nmiSyncReg <= '1;
      irqSyncReg <= '0;
    end else if (enable) begin
      nmiSyncReg[0] <= nNMI;
      irqSyncReg[0] <= irqIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nmiSyncReg[i] <= nmiSyncReg[i-1];
        irqSyncReg[i] <= irqSyncReg[i-1];
      end
    end
  end

  assign sNmi    = nmiSyncReg[SYNC_STAGES-1];
  assign sIrq    = irqSyncReg[SYNC_STAGES-1];
  assign nmiEdge = nmiPrevReg & ~sNmi;

`ifdef CPU6502_IRQ_EDGE_MODE_EN
  logic [IRQ_CHANNELS-1:0] irqPrevReg;
  logic [IRQ_CHANNELS-1:0] irqPendReg;

  // A fresh rising edge beats a simultaneous clear so no event is lost.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      irqPrevReg <= '0;
      irqPendReg <= '0;
    end else if (enable) begin
      irqPrevReg <= sIrq;
      irqPendReg <= irqEdgeMode & ((sIrq & ~irqPrevReg) | (irqPendReg & ~irqClear));
    end
  end

  for (genvar gi = 0; gi < IRQ_CHANNELS; gi++) begin : gIrqSource
    assign irqSource[gi] = irqEdgeMode[gi] ? irqPendReg[gi] : sIrq[gi];
  end
`else
  assign irqSource = sIrq;
`endif

  assign irqMasked = irqSource & irqMaskReg;
  assign irqActive = (|irqMasked) & ~core.iFlag;

  always_comb begin
    irqChannel = 3'd0;
    for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
      if (irqMasked[i]) irqChannel = 3'(i);
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stateReg    <= RESET_PEND;
      nmiPrevReg  <= 1'b1;
      nmiLatchReg <= 1'b0;
      irqMaskReg  <= '1;
    end else if (enable) begin
      stateReg    <= stateNext;
      nmiPrevReg  <= sNmi;
      nmiLatchReg <= nmiEdge | (nmiLatchReg & ~nmiCommit);
      if (maskWrite) irqMaskReg <= maskData;
    end
  end

  // In SERVICE the type is re-read from nmiLatch every cycle, so an NMI that
  // lands before vectorFetch hijacks the IRQ vector.
  always_comb begin
    stateNext      = stateReg;
    intRequestNext = 1'b0;
    intTypeNext    = TYPE_NONE;
    busyNext       = 1'b0;
    nmiCommit      = 1'b0;
    case (stateReg)
      RESET_PEND: begin
        intRequestNext = 1'b1;
        intTypeNext    = TYPE_RESET;
        if (core.vectorFetch) stateNext = IDLE;
      end
      IDLE: begin
        intRequestNext = nmiLatchReg | irqActive;
        if (nmiLatchReg)    intTypeNext = TYPE_NMI;
        else if (irqActive) intTypeNext = TYPE_IRQ;
        if (core.intAck && intRequestNext) begin
          if (core.vectorFetch) nmiCommit = nmiLatchReg;
          else                  stateNext = SERVICE;
        end
      end
      SERVICE: begin
        busyNext    = 1'b1;
        intTypeNext = nmiLatchReg ? TYPE_NMI : TYPE_IRQ;
        if (core.vectorFetch) begin
          nmiCommit = nmiLatchReg;
          stateNext = IDLE;
        end
      end
      default: stateNext = RESET_PEND;
    endcase
  end

  always_comb begin
    case (intTypeNext)
      TYPE_NMI:   vectorLowNext = 8'hFA;
      TYPE_RESET: vectorLowNext = 8'hFC;
      default:    vectorLowNext = 8'hFE;
    endcase
  end

  assign core.intRequest = intRequestNext;
  assign core.intType    = intTypeNext;
  assign core.vectorLow  = vectorLowNext;
  assign core.busy       = busyNext;
  assign irqMask         = irqMaskReg;

endmodule

// File: tb/tb_cpu6502_interrupt_controller.sv
// Directed and randomised checks of cpu6502_interrupt_controller against a queue-based reference model.
// Edge-mode checks are included when CPU6502_IRQ_EDGE_MODE_EN is defined.
module tb_cpu6502_interrupt_controller;
  localparam int N = 4;
  localparam int S = 2;

  logic         clock     = 1'b0;
  logic         nReset    = 1'b1;
  logic         enable    = 1'b1;
  logic         nNMI      = 1'b1;
  logic [N-1:0] irqIn     = '0;
  logic         maskWrite = 1'b0;
  logic [N-1:0] maskData  = '0;
  logic [2:0]   irqChannel;
  logic [N-1:0] irqMask;
`ifdef CPU6502_IRQ_EDGE_MODE_EN
  logic [N-1:0] irqEdgeMode = '0;
  logic [N-1:0] irqClear    = '0;
`endif

  cpu6502_interrupt_controller_if bus();

  cpu6502_interrupt_controller #(.IRQ_CHANNELS(N), .SYNC_STAGES(S)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .enable     (enable),
    .nNMI       (nNMI),
    .irqIn      (irqIn),
    .maskWrite  (maskWrite),
    .maskData   (maskData),
`ifdef CPU6502_IRQ_EDGE_MODE_EN
    .irqEdgeMode(irqEdgeMode),
    .irqClear   (irqClear),
`endif
    .irqChannel (irqChannel),
    .irqMask    (irqMask),
    .core       (bus)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: mode 0 = awaiting reset vector, 1 = idle, 2 = servicing.
  int           mMode;
  bit           mNmiLatch;
  bit           mPrevSNmi;
  logic [N-1:0] mMask;
  logic [N-1:0] mPend;
  logic [N-1:0] mPrevSIrq;
  bit           nmiHist[$];
  logic [N-1:0] irqHist[$];

  bit           eReq;
  bit           eBusy;
  logic [1:0]   eType;
  logic [7:0]   eVec;
  logic [2:0]   eChan;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode     = 0;
    mNmiLatch = 1'b0;
    mPrevSNmi = 1'b1;
    mMask     = '1;
    mPend     = '0;
    mPrevSIrq = '0;
    nmiHist   = {};
    irqHist   = {};
    for (int i = 0; i < S; i++) begin
      nmiHist.push_back(1'b1);
      irqHist.push_back('0);
    end
  endtask

  task automatic computeExpected();
    logic [N-1:0] src;
    logic [N-1:0] live;
    bit           act;
    bit           found;
    src = irqHist[0];
`ifdef CPU6502_IRQ_EDGE_MODE_EN
    src = (irqEdgeMode & mPend) | (~irqEdgeMode & irqHist[0]);
`endif
    live  = src & mMask;
    act   = (live != 0) && !bus.iFlag;
    eChan = 3'd0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (live[i] && !found) begin
        eChan = 3'(i);
        found = 1'b1;
      end
    end
    case (mMode)
      0: begin eReq = 1'b1; eType = 2'd3; end
      1: begin eReq = mNmiLatch || act; eType = mNmiLatch ? 2'd2 : (act ? 2'd1 : 2'd0); end
      default: begin eReq = 1'b0; eType = mNmiLatch ? 2'd2 : 2'd1; end
    endcase
    eBusy = (mMode == 2);
    eVec  = (eType == 2'd3) ? 8'hFC : (eType == 2'd2) ? 8'hFA : 8'hFE;
  endtask

  task automatic checkAll(input string tag);
    computeExpected();
    check({tag, ".intRequest"}, 32'(bus.intRequest), 32'(eReq));
    check({tag, ".intType"},    32'(bus.intType),    32'(eType));
    check({tag, ".vectorLow"},  32'(bus.vectorLow),  32'(eVec));
    check({tag, ".irqChannel"}, 32'(irqChannel),     32'(eChan));
    check({tag, ".irqMask"},    32'(irqMask),        32'(mMask));
    check({tag, ".busy"},       32'(bus.busy),       32'(eBusy));
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelStep();
    bit           sN;
    logic [N-1:0] sI;
    bit           newEdge;
    bit           commit;
    if (!enable) return;
    computeExpected();
    sN      = nmiHist[0];
    sI      = irqHist[0];
    newEdge = mPrevSNmi && !sN;
    commit  = bus.vectorFetch && mNmiLatch && (mMode == 2 || (mMode == 1 && bus.intAck));
    case (mMode)
      0: if (bus.vectorFetch) mMode = 1;
      1: if (bus.intAck && eReq && !bus.vectorFetch) mMode = 2;
      default: if (bus.vectorFetch) mMode = 1;
    endcase
    mNmiLatch = newEdge || (mNmiLatch && !commit);
    mPrevSNmi = sN;
`ifdef CPU6502_IRQ_EDGE_MODE_EN
    mPend = irqEdgeMode & ((sI & ~mPrevSIrq) | (mPend & ~irqClear));
`endif
    mPrevSIrq = sI;
    nmiHist.push_back(nNMI);
    void'(nmiHist.pop_front());
    irqHist.push_back(irqIn);
    void'(irqHist.pop_front());
    if (maskWrite) mMask = maskData;
  endtask

  task automatic tick(input string tag);
    #1;
    checkAll(tag);
    modelStep();
    @(negedge clock);
  endtask

  task automatic pulseReset();
    #2;
    nReset = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge clock);
    nReset = 1'b1;
  endtask

  initial begin
    bus.iFlag       = 1'b0;
    bus.intAck      = 1'b0;
    bus.vectorFetch = 1'b0;
    #1;
    nReset = 1'b0;
    modelReset();
    #1;
    check("rst.intRequest", 32'(bus.intRequest), 32'd1);
    check("rst.intType",    32'(bus.intType),    32'd3);
    check("rst.vectorLow",  32'(bus.vectorLow),  32'hFC);
    check("rst.irqChannel", 32'(irqChannel),     32'd0);
    check("rst.irqMask",    32'(irqMask),        32'hF);
    check("rst.busy",       32'(bus.busy),       32'd0);
    @(negedge clock);
    nReset = 1'b1;
    tick("boot");
    tick("boot");

    bus.vectorFetch = 1'b1;
    #1;
    check("boot.vecBefore",  32'(bus.vectorLow), 32'hFC);
    check("boot.typeBefore", 32'(bus.intType),   32'd3);
    tick("boot.vf");
    bus.vectorFetch = 1'b0;
    #1;
    check("boot.reqAfter", 32'(bus.intRequest), 32'd0);
    tick("boot.idle");

    irqIn = 4'b0100;
    tick("irq.sync");
    #1;
    check("irq.notYet", 32'(bus.intRequest), 32'd0);
    tick("irq.sync");
    #1;
    check("irq.req",  32'(bus.intRequest), 32'd1);
    check("irq.chan", 32'(irqChannel),     32'd2);
    check("irq.vec",  32'(bus.vectorLow),  32'hFE);
    bus.iFlag = 1'b1;
    tick("irq.iflag");
    #1;
    check("irq.iflagReq", 32'(bus.intRequest), 32'd0);
    bus.iFlag = 1'b0;
    irqIn = '0;
    repeat (3) tick("irq.clear");

    nNMI = 1'b0;
    repeat (10) tick("nmi.low");
    bus.intAck = 1'b1;
    #1;
    check("nmi.type", 32'(bus.intType), 32'd2);
    tick("nmi.ack");
    bus.intAck = 1'b0;
    #1;
    check("nmi.busy", 32'(bus.busy),       32'd1);
    check("nmi.svcReq", 32'(bus.intRequest), 32'd0);
    bus.vectorFetch = 1'b1;
    #1;
    check("nmi.vec", 32'(bus.vectorLow), 32'hFA);
    tick("nmi.vf");
    bus.vectorFetch = 1'b0;
    repeat (3) tick("nmi.held");
    #1;
    check("nmi.noRetrig", 32'(bus.intRequest), 32'd0);
    nNMI = 1'b1;
    repeat (3) tick("nmi.release");

    irqIn = 4'b0001;
    repeat (2) tick("hijack.irq");
    bus.intAck = 1'b1;
    tick("hijack.ack");
    bus.intAck = 1'b0;
    nNMI = 1'b0;
    #1;
    check("hijack.provType", 32'(bus.intType), 32'd1);
    repeat (3) tick("hijack.nmi");
    bus.vectorFetch = 1'b1;
    #1;
    check("hijack.vec", 32'(bus.vectorLow), 32'hFA);
    tick("hijack.vf");
    bus.vectorFetch = 1'b0;
    #1;
    check("hijack.irqStill", 32'(bus.intRequest), 32'd1);
    check("hijack.irqType",  32'(bus.intType),    32'd1);
    nNMI  = 1'b1;
    irqIn = '0;
    repeat (3) tick("hijack.clear");

    maskWrite = 1'b1;
    maskData  = 4'b1110;
    irqIn     = 4'b0001;
    tick("mask.write");
    maskWrite = 1'b0;
    repeat (2) tick("mask.sync");
    #1;
    check("mask.blocked", 32'(bus.intRequest), 32'd0);
    check("mask.value",   32'(irqMask),        32'hE);
    irqIn = 4'b0011;
    repeat (2) tick("mask.sync2");
    #1;
    check("mask.chan", 32'(irqChannel),     32'd1);
    check("mask.req",  32'(bus.intRequest), 32'd1);

    bus.intAck      = 1'b1;
    bus.vectorFetch = 1'b1;
    tick("ackvf");
    bus.intAck      = 1'b0;
    bus.vectorFetch = 1'b0;
    #1;
    check("ackvf.idle", 32'(bus.busy), 32'd0);

    bus.intAck = 1'b1;
    tick("abort.ack");
    bus.intAck = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd1);
    pulseReset();
    check("abort.type", 32'(bus.intType), 32'd3);
    irqIn = '0;
    bus.vectorFetch = 1'b1;
    tick("abort.boot");
    bus.vectorFetch = 1'b0;
    repeat (3) tick("abort.idle");

`ifdef CPU6502_IRQ_EDGE_MODE_EN
    irqEdgeMode = 4'b1000;
    irqIn       = 4'b1000;
    tick("edge.pulse");
    irqIn = '0;
    repeat (5) tick("edge.hold");
    #1;
    check("edge.held", 32'(bus.intRequest), 32'd1);
    check("edge.chan", 32'(irqChannel),     32'd3);
    irqClear = 4'b1000;
    tick("edge.clear");
    irqClear = '0;
    #1;
    check("edge.dropped", 32'(bus.intRequest), 32'd0);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) pulseReset();
      enable          = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) nNMI = ~nNMI;
      if ($urandom_range(0, 3) == 0) irqIn = N'($urandom);
      bus.iFlag       = ($urandom_range(0, 3) == 0);
      maskWrite       = ($urandom_range(0, 15) == 0);
      maskData        = N'($urandom);
      bus.intAck      = ($urandom_range(0, 3) == 0);
      bus.vectorFetch = ($urandom_range(0, 4) == 0);
`ifdef CPU6502_IRQ_EDGE_MODE_EN
      if ($urandom_range(0, 49) == 0) irqEdgeMode = N'($urandom);
      irqClear = N'($urandom) & N'($urandom);
`endif
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cpu6502_interrupt_controller.md
Name: cpu6502_interrupt_controller

Overview:
Parametrised interrupt/reset sequencer for the 6502 core, replacing the direct nNMI/nIRQ pin sampling in the CPU top level. It merges IRQ_CHANNELS maskable level sources, an edge-detected NMI and the post-reset request into one prioritised request. It exchanges a two-strobe handshake with the microcode sequencer and supplies the low byte of the 0xFFxx vector, including 6502-style NMI hijack of an in-progress IRQ.

Parameters:
IRQ_CHANNELS, 4, number of IRQ sources (1..8).
SYNC_STAGES, 2, synchroniser flops on nNMI and each irqIn bit (>=1).

Ports:
clock  in  1  system clock; all state changes on the rising edge.
nReset  in  1  asynchronous, active-low reset.
enable  in  1  clock enable; when low, all state holds (synchronisers included).
nNMI  in  1  NMI pin, active low, asynchronous.
irqIn  in  IRQ_CHANNELS  IRQ sources, active high, level, asynchronous.
maskWrite  in  1  load strobe for the mask register.
maskData  in  IRQ_CHANNELS  new mask value (1 = channel enabled).
iFlag  in  1  P register I bit from the core.
intAck  in  1  one-cycle pulse; the core has accepted the request at an instruction boundary.
vectorFetch  in  1  one-cycle pulse; the core is reading the vector low byte this cycle.
intRequest  out  1  an interrupt or reset is pending.
intType  out  2  0 none, 1 IRQ, 2 NMI, 3 RESET.
vectorLow  out  8  0xFE IRQ/none, 0xFA NMI, 0xFC RESET.
irqChannel  out  3  lowest-index active masked channel; 0 if none.
irqMask  out  IRQ_CHANNELS  current mask register.
busy  out  1  state is SERVICE.

Behaviour:
- Reset (async, nReset low): state RESET_PEND; synchronisers load 1 for nNMI and 0 for irqIn; nmiLatch=0; irqMask=all ones; intRequest=1; intType=3; vectorLow=0xFC; irqChannel=0; busy=0.
- Synchronisation: sNMI and sIRQ are the outputs of SYNC_STAGES flops. Latency from pin to request is SYNC_STAGES+1 enabled cycles for NMI and SYNC_STAGES for IRQ.
- NMI edge: nmiLatch sets on a sampled 1->0 transition of sNMI. It is not retriggered while sNMI stays low. It clears only at the vectorFetch that commits NMI. If a new edge and the clear occur in the same cycle, the set wins.
- irqActive = |(sIRQ & irqMask) & ~iFlag. It is not latched: if it drops before intAck, the request is withdrawn.
- Priority: RESET_PEND > nmiLatch > irqActive. intType and vectorLow follow the highest pending source combinationally from registered state.
- Mask: maskWrite loads maskData at the next edge and takes effect on irqActive in the same cycle as the load.
- FSM:
  - RESET_PEND: intAck is ignored; vectorFetch -> IDLE.
  - IDLE: intRequest = nmiLatch | irqActive; intAck while intRequest=1 -> SERVICE. intAck with no request is ignored.
  - SERVICE: busy=1 and intRequest=0. The type is provisional (IRQ, or NMI if nmiLatch). On vectorFetch the type is re-evaluated; an NMI latched during SERVICE overrides IRQ (hijack), giving vectorLow=0xFA that cycle. The type is then committed and the state returns to IDLE. If the IRQ source drops during SERVICE, the IRQ vector is still delivered (0xFE). Further intAck pulses are ignored.
- intAck and vectorFetch in the same cycle in IDLE: treated as ack followed by immediate commit; the controller stays in IDLE.
- Assertion of nReset mid-SERVICE aborts service and returns to RESET_PEND.

Optional Feature:
CPU6502_IRQ_EDGE_MODE_EN
- Defined: adds input irqEdgeMode[IRQ_CHANNELS] and input irqClear[IRQ_CHANNELS].
  - A channel with edgeMode=1 has a pending bit, set on a sampled 0->1 of sIRQ and cleared by irqClear (set wins on collision). The pending bit replaces the level in the irqActive term.
  - Pending bits reset to 0.
- Undefined: the ports are absent and all channels are level-sensitive.

Test Plan:
- Release nReset, then pulse vectorFetch -> vectorLow=0xFC and intType=3 before the pulse; after the pulse intRequest=0 and state is IDLE.
- irqIn=4'b0100, iFlag=0, mask=F -> intRequest after 2 cycles, irqChannel=2, vectorLow=0xFE. Then set iFlag=1 -> intRequest=0 next cycle.
- Drive nNMI low for 10 cycles -> exactly one latch; intAck then vectorFetch gives 0xFA. Afterwards intRequest=0 while nNMI stays low.
- Hijack: IRQ on channel 0, intAck, then nNMI falls 3 cycles before vectorFetch -> vectorLow=0xFA at vectorFetch, nmiLatch cleared, and a subsequent IRQ is still pending.
- Write maskWrite=1, maskData=4'b1110 with irqIn=4'b0001 -> intRequest=0; then irqIn=4'b0011 -> irqChannel=1.
- With CPU6502_IRQ_EDGE_MODE_EN: channel 3 in edge mode receives a 1-cycle pulse -> request held; irqClear[3] -> request drops next cycle.
